// File: rtl/image_mem_arbiter.sv
// rtl/image_mem_arbiter.sv - round-robin arbiter sharing the 160x120 image RAM between three requesters
//
// Requester 0 = scan reader, 1 = star cleaner, 2 = marker drawer.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req[2:0], we[2:0]    per-requester request and write flag (1 = write)
//   x_flat, y_flat       per-requester pixel coordinates, requester i at [i*W +: W]
//   wdata_flat           per-requester write colour
//   gnt[2:0]             combinational one-hot grant
//   rvalid[2:0], rdata   registered one-hot read strobe and read colour
//   oob                  one-cycle pulse when an out-of-range request is accepted
//   mem_addr/data/wren   registered RAM command
//   mem_q                RAM read data (RAM registers its address, 1-cycle latency)
module image_mem_arbiter #(
    parameter int XSZ    = 8,
    parameter int YSZ    = 7,
    parameter int DW     = 3,
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [2:0]       req,
    input  logic [2:0]       we,
    input  logic [3*XSZ-1:0] x_flat,
    input  logic [3*YSZ-1:0] y_flat,
    input  logic [3*DW-1:0]  wdata_flat,
    output logic [2:0]       gnt,
    output logic [2:0]       rvalid,
    output logic [DW-1:0]    rdata,
    output logic             oob,
    output logic [14:0]      mem_addr,
    output logic [DW-1:0]    mem_data,
    output logic             mem_wren,
    input  logic [DW-1:0]    mem_q
);

    logic [1:0]    r_last;
    logic [14:0]   r_mem_addr;
    logic [DW-1:0] r_mem_data;
    logic          r_mem_wren;
    logic          r_oob;
    logic          r_s1_valid, r_s1_oob;
    logic [1:0]    r_s1_idx;
    logic          r_s2_valid, r_s2_oob;
    logic [1:0]    r_s2_idx;
    logic [2:0]    r_rvalid;
    logic [DW-1:0] r_rdata;

    logic [XSZ-1:0] w_xs [3];
    logic [YSZ-1:0] w_ys [3];
    logic [DW-1:0]  w_ds [3];
    logic [1:0]     w_p0, w_p1, w_p2;
    logic [1:0]     w_idx;
    logic           w_any;
    logic [XSZ-1:0] w_x;
    logic [YSZ-1:0] w_y;
    logic [DW-1:0]  w_wd;
    logic           w_we;
    logic [14:0]    w_addr;
    logic           w_inrange;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_xs[i] = x_flat[i*XSZ +: XSZ];
            w_ys[i] = y_flat[i*YSZ +: YSZ];
            w_ds[i] = wdata_flat[i*DW +: DW];
        end
    end

    // Priority order is last+1, last+2, last (mod 3).
    always_comb begin
        w_p0 = 2'd0;
        w_p1 = 2'd1;
        w_p2 = 2'd2;
        case (r_last)
            2'd0: begin w_p0 = 2'd1; w_p1 = 2'd2; w_p2 = 2'd0; end
            2'd1: begin w_p0 = 2'd2; w_p1 = 2'd0; w_p2 = 2'd1; end
            default: ;
        endcase
        w_any = 1'b1;
        w_idx = w_p2;
        if (req[w_p0])      w_idx = w_p0;
        else if (req[w_p1]) w_idx = w_p1;
        else if (req[w_p2]) w_idx = w_p2;
        else                w_any = 1'b0;
    end

    assign gnt  = w_any ? (3'b001 << w_idx) : 3'b000;
    assign w_x  = w_xs[w_idx];
    assign w_y  = w_ys[w_idx];
    assign w_wd = w_ds[w_idx];
    assign w_we = we[w_idx];

    // y*160 + x as two shifts and an add.
    assign w_addr    = 15'({w_y, 7'b0}) + 15'({w_y, 5'b0}) + 15'(w_x);
    assign w_inrange = (int'(w_x) < WIDTH) && (int'(w_y) < HEIGHT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last     <= 2'd2;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_wren <= 1'b0;
            r_oob      <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_oob   <= 1'b0;
            r_s1_idx   <= 2'd0;
            r_s2_valid <= 1'b0;
            r_s2_oob   <= 1'b0;
            r_s2_idx   <= 2'd0;
            r_rvalid   <= 3'b000;
            r_rdata    <= '0;
        end else begin
            r_mem_wren <= 1'b0;
            r_oob      <= 1'b0;
            if (w_any) begin
                r_last <= w_idx;
                if (w_inrange) begin
                    r_mem_addr <= w_addr;
                    r_mem_data <= w_wd;
                    r_mem_wren <= w_we;
                end else begin
                    r_mem_addr <= '0;
                    r_oob      <= 1'b1;
                end
            end
            // Tag stages track the RAM: stage 1 beside mem_addr, stage 2 beside
            // the RAM's own address register; the output register then captures mem_q.
            r_s1_valid <= w_any & ~w_we;
            r_s1_idx   <= w_idx;
            r_s1_oob   <= ~w_inrange;
            r_s2_valid <= r_s1_valid;
            r_s2_idx   <= r_s1_idx;
            r_s2_oob   <= r_s1_oob;
            r_rvalid   <= r_s2_valid ? (3'b001 << r_s2_idx) : 3'b000;
            r_rdata    <= (r_s2_valid && !r_s2_oob) ? mem_q : '0;
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign mem_wren = r_mem_wren;
    assign oob      = r_oob;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// tb/tb_image_mem_arbiter.sv - self-checking bench for image_mem_arbiter against a pixel-level model
module tb_image_mem_arbiter;

    localparam int XSZ = 8, YSZ = 7, DW = 3, WIDTH = 160, HEIGHT = 120;

    logic             clk = 1'b0;
    logic             resetn;
    logic [2:0]       req, we;
    logic [3*XSZ-1:0] x_flat;
    logic [3*YSZ-1:0] y_flat;
    logic [3*DW-1:0]  wdata_flat;
    logic [2:0]       gnt, rvalid;
    logic [DW-1:0]    rdata, mem_data, mem_q;
    logic             oob, mem_wren;
    logic [14:0]      mem_addr;

    always #5 clk = ~clk;

    image_mem_arbiter #(.XSZ(XSZ), .YSZ(YSZ), .DW(DW), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk(clk), .resetn(resetn), .req(req), .we(we), .x_flat(x_flat), .y_flat(y_flat),
        .wdata_flat(wdata_flat), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .oob(oob),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    // Single-port RAM with registered address.
    logic [DW-1:0] ram [0:32767];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    // Requester-side stimulus state.
    logic           s_req [3];
    logic           s_we  [3];
    logic [XSZ-1:0] s_x   [3];
    logic [YSZ-1:0] s_y   [3];
    logic [DW-1:0]  s_d   [3];

    // Reference model: image contents, round-robin pointer, expected read returns.
    typedef struct { int due; logic [2:0] mask; logic [DW-1:0] data; } rsp_t;
    logic [DW-1:0] shadow [0:WIDTH*HEIGHT-1];
    rsp_t          rq [$];
    int            m_last;
    int            edge_n;
    int            acc_idx;
    logic [14:0]   e_addr;
    logic [DW-1:0] e_data;
    logic          e_wren, e_oob;
    int            vectors, miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            req[i]                 = s_req[i];
            we[i]                  = s_we[i];
            x_flat[i*XSZ +: XSZ]   = s_x[i];
            y_flat[i*YSZ +: YSZ]   = s_y[i];
            wdata_flat[i*DW +: DW] = s_d[i];
        end
    endtask

    task automatic set_rq(input int i, input logic r, input logic w, input int x, input int y, input int d);
        s_req[i] = r; s_we[i] = w; s_x[i] = XSZ'(x); s_y[i] = YSZ'(y); s_d[i] = DW'(d);
        drive();
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) s_req[i] = 1'b0;
        drive();
    endtask

    function automatic int pick(input int last);
        for (int k = 1; k <= 3; k++) begin
            if (s_req[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 2; rq.delete();
        e_addr = '0; e_data = '0; e_wren = 1'b0; e_oob = 1'b0;
    endtask

    // One clock: check the grant, predict the edge, then check registered outputs.
    task automatic cycle();
        int p, a;
        logic inr;
        rsp_t r, none;
        #1;
        p = pick(m_last);
        chk("gnt", 32'(gnt), (p < 0) ? 32'd0 : (32'd1 << p));
        acc_idx = -1;
        e_wren  = 1'b0;
        e_oob   = 1'b0;
        if (p >= 0 && resetn) begin
            acc_idx = p;
            m_last  = p;
            inr = (int'(s_x[p]) < WIDTH) && (int'(s_y[p]) < HEIGHT);
            a   = int'(s_y[p]) * WIDTH + int'(s_x[p]);
            if (inr) begin
                e_addr = 15'(a); e_data = s_d[p]; e_wren = s_we[p];
                if (s_we[p]) shadow[a] = s_d[p];
            end else begin
                e_addr = '0; e_oob = 1'b1;
            end
            if (!s_we[p]) begin
                r.due = edge_n + 3; r.mask = 3'b001 << p; r.data = inr ? shadow[a] : '0;
                rq.push_back(r);
            end
        end
        @(posedge clk);
        edge_n++;
        #2;
        chk("oob", 32'(oob), 32'(e_oob));
        chk("mem_wren", 32'(mem_wren), 32'(e_wren));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_data", 32'(mem_data), 32'(e_data));
        none.due = 0; none.mask = 3'b000; none.data = '0;
        r = none;
        if (rq.size() > 0 && rq[0].due == edge_n) r = rq.pop_front();
        chk("rvalid", 32'(rvalid), 32'(r.mask));
        if (r.mask != 3'b000) chk("rdata", 32'(rdata), 32'(r.data));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        model_reset();
        cycle();
        resetn = 1'b1;
    endtask

    initial begin
        vectors = 0; miscompares = 0; edge_n = 0; acc_idx = -1;
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_req[i] = 1'b0; s_we[i] = 1'b0; s_x[i] = '0; s_y[i] = '0; s_d[i] = '0;
        end
        drive();
        for (int i = 0; i < WIDTH*HEIGHT; i++) begin
            shadow[i] = DW'($urandom);
            if (i == 165) shadow[i] = 3'b101;
            ram[i] <= shadow[i];
        end
        model_reset();

        // Reset state; grant stays live during reset but nothing is accepted.
        @(posedge clk); #2;
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_oob", 32'(oob), 32'd0);
        for (int i = 0; i < 3; i++) set_rq(i, 1'b1, 1'b1, 7, 7, 6);
        cycle();
        clear_all();
        resetn = 1'b1;
        idle(1);

        // Read pixel (5,1) = address 165.
        set_rq(0, 1'b1, 1'b0, 5, 1, 0);
        cycle(); clear_all(); idle(3);

        // Write the last pixel, then read it back.
        set_rq(1, 1'b1, 1'b1, 159, 119, 3);
        cycle(); clear_all();
        set_rq(0, 1'b1, 1'b0, 159, 119, 0);
        cycle(); clear_all(); idle(3);

        // All three reading continuously from reset: order 0,1,2,0,1,2.
        pulse_reset();
        for (int i = 0; i < 3; i++) set_rq(i, 1'b1, 1'b0, 10 + i, 20 + i, 0);
        idle(6); clear_all(); idle(3);

        // Out-of-range write and read.
        set_rq(2, 1'b1, 1'b1, 160, 0, 5);
        cycle(); clear_all();
        set_rq(0, 1'b1, 1'b0, 0, 120, 0);
        cycle(); clear_all(); idle(3);

        // Reset while a read is in flight: no return, first grant after release is 001.
        set_rq(0, 1'b1, 1'b0, 3, 3, 0);
        cycle();
        resetn = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) set_rq(i, 1'b1, 1'b0, 4, 4 + i, 0);
        cycle();
        resetn = 1'b1;
        cycle(); clear_all(); idle(4);

        // Single requester streaming addresses 0..3 back to back.
        for (int k = 0; k < 4; k++) begin
            set_rq(0, 1'b1, 1'b0, k, 0, 0);
            cycle();
        end
        clear_all(); idle(3);

        // Randomized traffic; requests held until accepted.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!s_req[i] || acc_idx == i) begin
                    s_req[i] = ($urandom_range(0, 9) < 6);
                    s_we[i]  = $urandom_range(0, 2) == 0;
                    if ($urandom_range(0, 1) == 0) begin
                        s_x[i] = XSZ'($urandom_range(0, 3));
                        s_y[i] = YSZ'($urandom_range(0, 1));
                    end else begin
                        s_x[i] = ($urandom_range(0, 9) == 0) ? XSZ'($urandom_range(160, 255)) : XSZ'($urandom_range(0, 159));
                        s_y[i] = ($urandom_range(0, 9) == 0) ? YSZ'($urandom_range(120, 127)) : YSZ'($urandom_range(0, 119));
                    end
                    s_d[i] = DW'($urandom);
                end
            end
            drive();
            if ($urandom_range(0, 149) == 0) pulse_reset();
            else cycle();
        end
        clear_all(); idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
